// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: command encoding,
// boolean constants and requester identifiers.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        MEM_CMD_NONE  = 2'd0,
        MEM_CMD_LOAD  = 2'd1,
        MEM_CMD_STORE = 2'd2
    } mem_cmd_t;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic [1:0] {
        REQ_IF = 2'd0,
        REQ_LD = 2'd1,
        REQ_ST = 2'd2
    } req_id_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester, memory and status signals around mem_arbiter.
// master: the arbiter's view; slave: the caches and memory model.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int TAG_W = 4,
    parameter int IDX_W = 16,
    parameter int BLK_W = 64
) ();

    mem_cmd_t             if_qry_cmd, ld_qry_cmd, st_qry_cmd;
    logic [IDX_W-1:0]     if_qry_idx, ld_qry_idx, st_qry_idx;
    logic [BLK_W-1:0]     st_qry_blk;
    logic [TAG_W-1:0]     if_ack, ld_ack, st_ack;
    logic [TAG_W-1:0]     if_ans_tag, ld_ans_tag;
    logic [BLK_W-1:0]     if_ans_blk, ld_ans_blk;
    mem_cmd_t             mem_qry_cmd;
    logic [IDX_W-1:0]     mem_qry_idx;
    logic [BLK_W-1:0]     mem_qry_blk;
    logic [TAG_W-1:0]     mem_ack;
    logic [TAG_W-1:0]     mem_ans_tag;
    logic [BLK_W-1:0]     mem_ans_blk;
    logic                 err;

    modport master (
        input  if_qry_cmd, ld_qry_cmd, st_qry_cmd,
        input  if_qry_idx, ld_qry_idx, st_qry_idx, st_qry_blk,
        output if_ack, ld_ack, st_ack,
        output if_ans_tag, ld_ans_tag, if_ans_blk, ld_ans_blk,
        output mem_qry_cmd, mem_qry_idx, mem_qry_blk,
        input  mem_ack, mem_ans_tag, mem_ans_blk,
        output err
    );

    modport slave (
        output if_qry_cmd, ld_qry_cmd, st_qry_cmd,
        output if_qry_idx, ld_qry_idx, st_qry_idx, st_qry_blk,
        input  if_ack, ld_ack, st_ack,
        input  if_ans_tag, ld_ans_tag, if_ans_blk, ld_ans_blk,
        input  mem_qry_cmd, mem_qry_idx, mem_qry_blk,
        output mem_ack, mem_ans_tag, mem_ans_blk,
        input  err
    );

endinterface

// File: rtl/mem_tag_table.sv
// Owner table for outstanding load tags. Written when memory acks a load,
// looked up and cleared when memory answers. A write and a clear to the
// same tag in one cycle leave the entry valid with the new owner.
module mem_tag_table
    import mem_arbiter_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  req_id_t          wr_owner_i,
    output logic             wr_busy_o,
    input  logic [TAG_W-1:0] lk_tag_i,
    input  logic             clr_en_i,
    output logic             lk_valid_o,
    output req_id_t          lk_owner_o
);

    localparam int DEPTH = 1 << TAG_W;

    logic    valid_q [DEPTH];
    req_id_t owner_q [DEPTH];

    // Both ports read the table as it stood at the start of the cycle.
    assign wr_busy_o  = valid_q[wr_tag_i];
    assign lk_valid_o = valid_q[lk_tag_i];
    assign lk_owner_o = owner_q[lk_tag_i];

    // Valid bits: clear on answer, then set on ack so a same-tag write wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= FALSE;
            end
        end else begin
            // NOTE: non-blocking assignments make the later write win over the
            // earlier clear for the same index, and keep every read on old state.
            if (clr_en_i) valid_q[lk_tag_i] <= FALSE;
            if (wr_en_i)  valid_q[wr_tag_i] <= TRUE;
        end
    end

    // Owner payload: captured on ack.
    // NOTE: the payload array needs no reset; an entry is only read while its
    // valid bit is set, and that bit is always reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) owner_q[wr_tag_i] <= wr_owner_i;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch loads, data loads and evict write-backs onto one tagged
// memory port, returns the accepted tag to the winner and steers answers
// back to the requester that owns each load tag.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TAG_W = 4,
    parameter int IDX_W = 16,
    parameter int BLK_W = 64
) (
    input  logic          clock,
    input  logic          reset,
    mem_arbiter_if.master bus
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]       state_q, state_d;
    req_id_t          grant_q, grant_d;
    logic             rr_ld_q, rr_ld_d;        // 1: ld wins an if/ld tie
    mem_cmd_t         qry_cmd_q, qry_cmd_d;
    logic [IDX_W-1:0] qry_idx_q, qry_idx_d;
    logic [BLK_W-1:0] qry_blk_q, qry_blk_d;
    logic [TAG_W-1:0] if_ack_q, if_ack_d, ld_ack_q, ld_ack_d, st_ack_q, st_ack_d;
    logic [TAG_W-1:0] if_ans_tag_q, if_ans_tag_d, ld_ans_tag_q, ld_ans_tag_d;
    logic [BLK_W-1:0] if_ans_blk_q, if_ans_blk_d, ld_ans_blk_q, ld_ans_blk_d;
    logic             err_q, err_d;

    logic    if_req, ld_req, st_req;
    logic    tbl_wr_en, tbl_wr_busy, tbl_lk_valid, ans_hit, ans_unknown;
    req_id_t tbl_lk_owner;

    assign if_req = (bus.if_qry_cmd != MEM_CMD_NONE);
    assign ld_req = (bus.ld_qry_cmd != MEM_CMD_NONE);
    assign st_req = (bus.st_qry_cmd != MEM_CMD_NONE);

    // A load ack claims a tag for its requester; store acks claim nothing.
    assign tbl_wr_en = (state_q == BUSY) && (bus.mem_ack != '0) &&
                       (qry_cmd_q == MEM_CMD_LOAD) && (grant_q != REQ_ST);

    assign ans_hit     = (bus.mem_ans_tag != '0) && tbl_lk_valid;
    assign ans_unknown = (bus.mem_ans_tag != '0) && !tbl_lk_valid;

    mem_tag_table #(.TAG_W(TAG_W)) u_tag_table (
        .clk        (clock),
        .rst_n      (reset),
        .wr_en_i    (tbl_wr_en),
        .wr_tag_i   (bus.mem_ack),
        .wr_owner_i (grant_q),
        .wr_busy_o  (tbl_wr_busy),
        .lk_tag_i   (bus.mem_ans_tag),
        .clr_en_i   (ans_hit),
        .lk_valid_o (tbl_lk_valid),
        .lk_owner_o (tbl_lk_owner)
    );

    // Arbitration FSM: pick a winner in IDLE, hold the query until memory acks.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave a latch behind.
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ld_d   = rr_ld_q;
        qry_cmd_d = qry_cmd_q;
        qry_idx_d = qry_idx_q;
        qry_blk_d = qry_blk_q;
        if_ack_d  = '0;
        ld_ack_d  = '0;
        st_ack_d  = '0;
        case (state_q)
            IDLE: begin
                if (st_req) begin
                    grant_d   = REQ_ST;
                    qry_cmd_d = bus.st_qry_cmd;
                    qry_idx_d = bus.st_qry_idx;
                    qry_blk_d = bus.st_qry_blk;
                    state_d   = BUSY;
                end else if (ld_req && (!if_req || rr_ld_q)) begin
                    grant_d   = REQ_LD;
                    qry_cmd_d = bus.ld_qry_cmd;
                    qry_idx_d = bus.ld_qry_idx;
                    qry_blk_d = '0;
                    rr_ld_d   = ~rr_ld_q;
                    state_d   = BUSY;
                end else if (if_req) begin
                    grant_d   = REQ_IF;
                    qry_cmd_d = bus.if_qry_cmd;
                    qry_idx_d = bus.if_qry_idx;
                    qry_blk_d = '0;
                    rr_ld_d   = ~rr_ld_q;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (bus.mem_ack != '0) begin
                    case (grant_q)
                        REQ_IF:  if_ack_d = bus.mem_ack;
                        REQ_LD:  ld_ack_d = bus.mem_ack;
                        default: st_ack_d = bus.mem_ack;
                    endcase
                    qry_cmd_d = MEM_CMD_NONE;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Answer steering and sticky protocol error, independent of FSM state.
    always_comb begin
        if_ans_tag_d = '0;
        ld_ans_tag_d = '0;
        if_ans_blk_d = '0;
        ld_ans_blk_d = '0;
        if (ans_hit) begin
            if (tbl_lk_owner == REQ_IF) begin
                if_ans_tag_d = bus.mem_ans_tag;
                if_ans_blk_d = bus.mem_ans_blk;
            end else begin
                ld_ans_tag_d = bus.mem_ans_tag;
                ld_ans_blk_d = bus.mem_ans_blk;
            end
        end
        err_d = err_q | ans_unknown | (tbl_wr_en && tbl_wr_busy);
    end

    // State and output registers; reset abandons any outstanding query.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            grant_q      <= REQ_LD;
            rr_ld_q      <= TRUE;
            qry_cmd_q    <= MEM_CMD_NONE;
            qry_idx_q    <= '0;
            qry_blk_q    <= '0;
            if_ack_q     <= '0;
            ld_ack_q     <= '0;
            st_ack_q     <= '0;
            if_ans_tag_q <= '0;
            ld_ans_tag_q <= '0;
            if_ans_blk_q <= '0;
            ld_ans_blk_q <= '0;
            err_q        <= FALSE;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rr_ld_q      <= rr_ld_d;
            qry_cmd_q    <= qry_cmd_d;
            qry_idx_q    <= qry_idx_d;
            qry_blk_q    <= qry_blk_d;
            if_ack_q     <= if_ack_d;
            ld_ack_q     <= ld_ack_d;
            st_ack_q     <= st_ack_d;
            if_ans_tag_q <= if_ans_tag_d;
            ld_ans_tag_q <= ld_ans_tag_d;
            if_ans_blk_q <= if_ans_blk_d;
            ld_ans_blk_q <= ld_ans_blk_d;
            err_q        <= err_d;
        end
    end

    assign bus.mem_qry_cmd = qry_cmd_q;
    assign bus.mem_qry_idx = qry_idx_q;
    assign bus.mem_qry_blk = qry_blk_q;
    assign bus.if_ack      = if_ack_q;
    assign bus.ld_ack      = ld_ack_q;
    assign bus.st_ack      = st_ack_q;
    assign bus.if_ans_tag  = if_ans_tag_q;
    assign bus.ld_ans_tag  = ld_ans_tag_q;
    assign bus.if_ans_blk  = if_ans_blk_q;
    assign bus.ld_ans_blk  = ld_ans_blk_q;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by a
// randomized run against a transaction-level model of requesters and memory.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int R_IF = 0;
    localparam int R_LD = 1;
    localparam int R_ST = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    mem_arbiter_if #(.TAG_W(4), .IDX_W(16), .BLK_W(64)) bus ();

    mem_arbiter #(.TAG_W(4), .IDX_W(16), .BLK_W(64)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        bus.if_qry_cmd = MEM_CMD_NONE; bus.if_qry_idx = '0;
        bus.ld_qry_cmd = MEM_CMD_NONE; bus.ld_qry_idx = '0;
        bus.st_qry_cmd = MEM_CMD_NONE; bus.st_qry_idx = '0; bus.st_qry_blk = '0;
        bus.mem_ack = '0; bus.mem_ans_tag = '0; bus.mem_ans_blk = '0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        idle_inputs();
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        reset = 1'b0;
        tick();
        checks++;
        if ({bus.mem_qry_cmd, bus.mem_qry_idx, bus.mem_qry_blk} !== '0) begin
            failures++;
            $display("FAIL reset_qry got cmd=%0d idx=%h blk=%h exp all 0",
                     bus.mem_qry_cmd, bus.mem_qry_idx, bus.mem_qry_blk);
        end
        checks++;
        if ({bus.if_ack, bus.ld_ack, bus.st_ack, bus.if_ans_tag, bus.ld_ans_tag,
             bus.if_ans_blk, bus.ld_ans_blk, bus.err} !== '0) begin
            failures++;
            $display("FAIL reset_outs got acks=%h/%h/%h ans=%h/%h err=%b exp all 0",
                     bus.if_ack, bus.ld_ack, bus.st_ack, bus.if_ans_tag, bus.ld_ans_tag, bus.err);
        end
        reset = 1'b1;
    endtask

    task automatic test_single_load();
        apply_reset();
        bus.ld_qry_cmd = MEM_CMD_LOAD; bus.ld_qry_idx = 16'd2;
        tick();
        checks++;
        if (bus.mem_qry_cmd !== MEM_CMD_LOAD || bus.mem_qry_idx !== 16'd2) begin
            failures++;
            $display("FAIL single_grant got cmd=%0d idx=%h exp cmd=1 idx=0002", bus.mem_qry_cmd, bus.mem_qry_idx);
        end
        tick();
        bus.mem_ack = 4'd1;
        tick();
        checks++;
        if (bus.ld_ack !== 4'd1 || bus.mem_qry_cmd !== MEM_CMD_NONE) begin
            failures++;
            $display("FAIL single_ack got ld_ack=%0d cmd=%0d exp ld_ack=1 cmd=0", bus.ld_ack, bus.mem_qry_cmd);
        end
        bus.mem_ack = '0; bus.ld_qry_cmd = MEM_CMD_NONE;
        tick();
        checks++;
        if (bus.ld_ack !== 4'd0) begin
            failures++;
            $display("FAIL single_ack_pulse got ld_ack=%0d exp 0", bus.ld_ack);
        end
        bus.mem_ans_tag = 4'd1; bus.mem_ans_blk = 64'hdeadbeefcc00ffee;
        tick();
        checks++;
        if (bus.ld_ans_tag !== 4'd1 || bus.ld_ans_blk !== 64'hdeadbeefcc00ffee || bus.if_ans_tag !== 4'd0) begin
            failures++;
            $display("FAIL single_answer got ld_tag=%0d blk=%h if_tag=%0d exp 1 deadbeefcc00ffee 0",
                     bus.ld_ans_tag, bus.ld_ans_blk, bus.if_ans_tag);
        end
        bus.mem_ans_tag = '0;
        tick();
        checks++;
        if (bus.ld_ans_tag !== 4'd0 || bus.err !== 1'b0) begin
            failures++;
            $display("FAIL single_after got ld_tag=%0d err=%b exp 0 0", bus.ld_ans_tag, bus.err);
        end
    endtask

    task automatic test_round_robin();
        logic [15:0] if_idx, ld_idx, exp_idx;
        logic [3:0]  exp_if, exp_ld;
        apply_reset();
        if_idx = 16'h0100; ld_idx = 16'h0200;
        bus.if_qry_cmd = MEM_CMD_LOAD; bus.ld_qry_cmd = MEM_CMD_LOAD;
        for (int g = 0; g < 4; g++) begin
            bus.if_qry_idx = if_idx; bus.ld_qry_idx = ld_idx;
            tick();
            exp_idx = (g % 2 == 0) ? ld_idx : if_idx;
            checks++;
            if (bus.mem_qry_cmd !== MEM_CMD_LOAD || bus.mem_qry_idx !== exp_idx) begin
                failures++;
                $display("FAIL rr_grant%0d got cmd=%0d idx=%h exp cmd=1 idx=%h", g, bus.mem_qry_cmd, bus.mem_qry_idx, exp_idx);
            end
            bus.mem_ack = 4'(g + 1);
            tick();
            exp_ld = (g % 2 == 0) ? 4'(g + 1) : 4'd0;
            exp_if = (g % 2 == 1) ? 4'(g + 1) : 4'd0;
            checks++;
            if (bus.ld_ack !== exp_ld || bus.if_ack !== exp_if || bus.mem_qry_cmd !== MEM_CMD_NONE) begin
                failures++;
                $display("FAIL rr_ack%0d got ld=%0d if=%0d cmd=%0d exp ld=%0d if=%0d cmd=0",
                         g, bus.ld_ack, bus.if_ack, bus.mem_qry_cmd, exp_ld, exp_if);
            end
            bus.mem_ack = '0;
            if (g % 2 == 0) ld_idx++; else if_idx++;
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_store_priority();
        logic [63:0] blk;
        apply_reset();
        blk = {$urandom(), $urandom()};
        bus.st_qry_cmd = MEM_CMD_STORE; bus.st_qry_idx = 16'h0030; bus.st_qry_blk = blk;
        bus.if_qry_cmd = MEM_CMD_LOAD;  bus.if_qry_idx = 16'h0011;
        bus.ld_qry_cmd = MEM_CMD_LOAD;  bus.ld_qry_idx = 16'h0022;
        tick();
        checks++;
        if (bus.mem_qry_cmd !== MEM_CMD_STORE || bus.mem_qry_idx !== 16'h0030 || bus.mem_qry_blk !== blk) begin
            failures++;
            $display("FAIL st_grant got cmd=%0d idx=%h blk=%h exp cmd=2 idx=0030 blk=%h",
                     bus.mem_qry_cmd, bus.mem_qry_idx, bus.mem_qry_blk, blk);
        end
        bus.mem_ack = 4'd6;
        tick();
        checks++;
        if (bus.st_ack !== 4'd6 || bus.if_ack !== 4'd0 || bus.ld_ack !== 4'd0) begin
            failures++;
            $display("FAIL st_ack got st=%0d if=%0d ld=%0d exp 6 0 0", bus.st_ack, bus.if_ack, bus.ld_ack);
        end
        bus.st_qry_cmd = MEM_CMD_NONE; bus.mem_ack = '0;
        tick();
        checks++;
        if (bus.mem_qry_cmd !== MEM_CMD_LOAD || bus.mem_qry_idx !== 16'h0022) begin
            failures++;
            $display("FAIL st_next_grant got cmd=%0d idx=%h exp cmd=1 idx=0022", bus.mem_qry_cmd, bus.mem_qry_idx);
        end
        bus.mem_ack = 4'd7;
        tick();
        idle_inputs();
        bus.mem_ans_tag = 4'd6;
        tick();
        bus.mem_ans_tag = '0;
        checks++;
        if (bus.if_ans_tag !== 4'd0 || bus.ld_ans_tag !== 4'd0 || bus.err !== 1'b1) begin
            failures++;
            $display("FAIL st_no_owner got if_tag=%0d ld_tag=%0d err=%b exp 0 0 1", bus.if_ans_tag, bus.ld_ans_tag, bus.err);
        end
    endtask

    task automatic test_out_of_order();
        logic [63:0] blk_a, blk_b;
        apply_reset();
        blk_a = {$urandom(), $urandom()};
        blk_b = {$urandom(), $urandom()};
        bus.if_qry_cmd = MEM_CMD_LOAD; bus.if_qry_idx = 16'h0040;
        tick();
        checks++;
        if (bus.mem_qry_cmd !== MEM_CMD_LOAD || bus.mem_qry_idx !== 16'h0040) begin
            failures++;
            $display("FAIL ooo_if_grant got cmd=%0d idx=%h exp cmd=1 idx=0040", bus.mem_qry_cmd, bus.mem_qry_idx);
        end
        bus.mem_ack = 4'd2;
        tick();
        bus.if_qry_cmd = MEM_CMD_NONE; bus.mem_ack = '0;
        bus.ld_qry_cmd = MEM_CMD_LOAD; bus.ld_qry_idx = 16'h0050;
        tick();
        checks++;
        if (bus.mem_qry_cmd !== MEM_CMD_LOAD || bus.mem_qry_idx !== 16'h0050) begin
            failures++;
            $display("FAIL ooo_ld_grant got cmd=%0d idx=%h exp cmd=1 idx=0050", bus.mem_qry_cmd, bus.mem_qry_idx);
        end
        bus.mem_ack = 4'd3;
        tick();
        idle_inputs();
        bus.mem_ans_tag = 4'd3; bus.mem_ans_blk = blk_a;
        tick();
        checks++;
        if (bus.ld_ans_tag !== 4'd3 || bus.ld_ans_blk !== blk_a || bus.if_ans_tag !== 4'd0) begin
            failures++;
            $display("FAIL ooo_first got ld_tag=%0d blk=%h if_tag=%0d exp 3 %h 0", bus.ld_ans_tag, bus.ld_ans_blk, bus.if_ans_tag, blk_a);
        end
        bus.mem_ans_tag = 4'd2; bus.mem_ans_blk = blk_b;
        tick();
        checks++;
        if (bus.if_ans_tag !== 4'd2 || bus.if_ans_blk !== blk_b || bus.ld_ans_tag !== 4'd0) begin
            failures++;
            $display("FAIL ooo_second got if_tag=%0d blk=%h ld_tag=%0d exp 2 %h 0", bus.if_ans_tag, bus.if_ans_blk, bus.ld_ans_tag, blk_b);
        end
        bus.mem_ans_tag = '0;
        tick();
        checks++;
        if (bus.err !== 1'b0) begin
            failures++;
            $display("FAIL ooo_err got err=%b exp 0", bus.err);
        end
    endtask

    task automatic test_unknown_tag();
        apply_reset();
        bus.mem_ans_tag = 4'd5; bus.mem_ans_blk = 64'h1234;
        tick();
        bus.mem_ans_tag = '0;
        checks++;
        if (bus.if_ans_tag !== 4'd0 || bus.ld_ans_tag !== 4'd0 || bus.err !== 1'b1) begin
            failures++;
            $display("FAIL unknown_tag got if_tag=%0d ld_tag=%0d err=%b exp 0 0 1", bus.if_ans_tag, bus.ld_ans_tag, bus.err);
        end
        repeat (3) tick();
        checks++;
        if (bus.err !== 1'b1) begin
            failures++;
            $display("FAIL unknown_sticky got err=%b exp 1", bus.err);
        end
    endtask

    task automatic test_reset_busy();
        apply_reset();
        bus.ld_qry_cmd = MEM_CMD_LOAD; bus.ld_qry_idx = 16'h0060;
        tick();
        bus.mem_ack = 4'd4;
        tick();
        checks++;
        if (bus.ld_ack !== 4'd4) begin
            failures++;
            $display("FAIL rstb_ack got ld_ack=%0d exp 4", bus.ld_ack);
        end
        bus.mem_ack = '0; bus.ld_qry_cmd = MEM_CMD_NONE;
        bus.if_qry_cmd = MEM_CMD_LOAD; bus.if_qry_idx = 16'h0070;
        tick();
        checks++;
        if (bus.mem_qry_cmd !== MEM_CMD_LOAD) begin
            failures++;
            $display("FAIL rstb_busy got cmd=%0d exp 1", bus.mem_qry_cmd);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (bus.mem_qry_cmd !== MEM_CMD_NONE || bus.err !== 1'b0) begin
            failures++;
            $display("FAIL rstb_async got cmd=%0d err=%b exp 0 0", bus.mem_qry_cmd, bus.err);
        end
        tick();
        tick();
        reset = 1'b1;
        idle_inputs();
        bus.mem_ans_tag = 4'd4; bus.mem_ans_blk = 64'h55;
        tick();
        bus.mem_ans_tag = '0;
        checks++;
        if (bus.err !== 1'b1 || bus.ld_ans_tag !== 4'd0) begin
            failures++;
            $display("FAIL rstb_lost got err=%b ld_tag=%0d exp 1 0", bus.err, bus.ld_ans_tag);
        end
    endtask

    // Transaction model: pending requests, an arbiter that is either free or
    // holding one query, and a map from tag to owning requester.
    task automatic test_random();
        int          owner_of [16];
        bit          req_on [3];
        logic [15:0] r_idx [3];
        logic [63:0] r_blk;
        bit          m_busy, rr_ld, drain;
        int          m_win, drv_owner, pick;
        logic [15:0] m_idx;
        logic [63:0] m_blk, drv_blk;
        logic [3:0]  drv_ack, drv_ans;
        logic [11:0] exp_acks;
        logic [3:0]  exp_if_tag, exp_ld_tag;
        logic [63:0] exp_if_blk, exp_ld_blk;
        mem_cmd_t    exp_cmd;
        int          q [$];
        apply_reset();
        for (int i = 0; i < 16; i++) owner_of[i] = -1;
        for (int r = 0; r < 3; r++) begin req_on[r] = 0; r_idx[r] = '0; end
        r_blk = '0; m_busy = 0; rr_ld = 1; m_win = R_LD; m_idx = '0; m_blk = '0;
        drv_ack = '0; drv_ans = '0; drv_blk = '0; drv_owner = -1;
        for (int cyc = 0; cyc < 1600; cyc++) begin
            drain = (cyc >= 1400);
            tick();
            exp_acks = '0;
            exp_cmd  = MEM_CMD_NONE;
            if (drv_ack != '0) begin
                exp_acks[4*(2-m_win) +: 4] = drv_ack;
                if (m_win != R_ST) owner_of[drv_ack] = m_win;
                req_on[m_win] = 0;
                m_busy = 0;
            end else if (m_busy) begin
                exp_cmd = (m_win == R_ST) ? MEM_CMD_STORE : MEM_CMD_LOAD;
            end else if (req_on[R_IF] || req_on[R_LD] || req_on[R_ST]) begin
                if (req_on[R_ST]) m_win = R_ST;
                else if (req_on[R_LD] && (!req_on[R_IF] || rr_ld)) m_win = R_LD;
                else m_win = R_IF;
                if (m_win != R_ST) rr_ld = !rr_ld;
                m_idx = r_idx[m_win];
                m_blk = r_blk;
                m_busy = 1;
                exp_cmd = (m_win == R_ST) ? MEM_CMD_STORE : MEM_CMD_LOAD;
            end
            checks++;
            if (bus.mem_qry_cmd !== exp_cmd || (exp_cmd != MEM_CMD_NONE && bus.mem_qry_idx !== m_idx) ||
                (exp_cmd == MEM_CMD_STORE && bus.mem_qry_blk !== m_blk)) begin
                failures++;
                $display("FAIL rnd_qry cyc=%0d got cmd=%0d idx=%h blk=%h exp cmd=%0d idx=%h blk=%h",
                         cyc, bus.mem_qry_cmd, bus.mem_qry_idx, bus.mem_qry_blk, exp_cmd, m_idx, m_blk);
            end
            checks++;
            if ({bus.if_ack, bus.ld_ack, bus.st_ack} !== exp_acks) begin
                failures++;
                $display("FAIL rnd_ack cyc=%0d got if/ld/st=%h exp %h", cyc, {bus.if_ack, bus.ld_ack, bus.st_ack}, exp_acks);
            end
            exp_if_tag = (drv_ans != '0 && drv_owner == R_IF) ? drv_ans : '0;
            exp_ld_tag = (drv_ans != '0 && drv_owner == R_LD) ? drv_ans : '0;
            exp_if_blk = (exp_if_tag != '0) ? drv_blk : bus.if_ans_blk;
            exp_ld_blk = (exp_ld_tag != '0) ? drv_blk : bus.ld_ans_blk;
            checks++;
            if (bus.if_ans_tag !== exp_if_tag || bus.ld_ans_tag !== exp_ld_tag ||
                bus.if_ans_blk !== exp_if_blk || bus.ld_ans_blk !== exp_ld_blk || bus.err !== 1'b0) begin
                failures++;
                $display("FAIL rnd_ans cyc=%0d got if=%0d ld=%0d err=%b exp if=%0d ld=%0d blk=%h err=0",
                         cyc, bus.if_ans_tag, bus.ld_ans_tag, bus.err, exp_if_tag, exp_ld_tag, drv_blk);
            end
            // Memory answers an owned tag, acked at least one cycle earlier.
            drv_ans = '0; drv_owner = -1;
            q.delete();
            for (int t = 1; t < 16; t++) if (owner_of[t] >= 0) q.push_back(t);
            if (q.size() > 0 && (drain || $urandom_range(2) == 0)) begin
                pick = q[$urandom_range(q.size() - 1)];
                drv_ans = 4'(pick); drv_owner = owner_of[pick]; owner_of[pick] = -1;
                drv_blk = {$urandom(), $urandom()};
            end
            // Memory accepts the open query with a tag nobody owns.
            drv_ack = '0;
            q.delete();
            for (int t = 1; t < 16; t++) if (owner_of[t] < 0 && 4'(t) != drv_ans) q.push_back(t);
            if (m_busy && q.size() > 0 && (drain || $urandom_range(1) == 0))
                drv_ack = 4'(q[$urandom_range(q.size() - 1)]);
            // Idle requesters raise new queries.
            for (int r = 0; r < 3; r++) begin
                if (!req_on[r] && !drain && $urandom_range(2) == 0) begin
                    req_on[r] = 1;
                    r_idx[r] = 16'($urandom());
                    if (r == R_ST) r_blk = {$urandom(), $urandom()};
                end
            end
            bus.if_qry_cmd = req_on[R_IF] ? MEM_CMD_LOAD : MEM_CMD_NONE;  bus.if_qry_idx = r_idx[R_IF];
            bus.ld_qry_cmd = req_on[R_LD] ? MEM_CMD_LOAD : MEM_CMD_NONE;  bus.ld_qry_idx = r_idx[R_LD];
            bus.st_qry_cmd = req_on[R_ST] ? MEM_CMD_STORE : MEM_CMD_NONE; bus.st_qry_idx = r_idx[R_ST];
            bus.st_qry_blk = r_blk;
            bus.mem_ack = drv_ack; bus.mem_ans_tag = drv_ans; bus.mem_ans_blk = drv_blk;
        end
        q.delete();
        for (int t = 1; t < 16; t++) if (owner_of[t] >= 0) q.push_back(t);
        checks++;
        if (q.size() != 0 || m_busy || req_on[R_IF] || req_on[R_LD] || req_on[R_ST]) begin
            failures++;
            $display("FAIL rnd_drain got owned=%0d busy=%b exp 0 0", q.size(), m_busy);
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_load();
        test_round_robin();
        test_store_priority();
        test_out_of_order();
        test_unknown_tag();
        test_reset_busy();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
